iq_dump_decimator: RTL and testbench

- Integrate-and-dump (boxcar) decimator placed directly downstream of the mixer.
- Consumes the mixer's interleaved complex stream: real sample on the first valid cycle, imaginary sample on the immediately following valid cycle.
- Sums DECIM consecutive I/Q pairs and emits one summed pair in the same interleaved format.
- Output feeds the magnitude/detection stages at the decimated rate.

---
 rtl/iq_dump_decimator.sv | 117 +++++++++++
 tb/tb_iq_dump_decimator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iq_dump_decimator.sv
// Integrate-and-dump decimator for an interleaved I/Q stream (re then im per pair).
// Define IQ_DECIM_AVG_EN to emit averages (sum >>> LOG2_DECIM) instead of full sums.
module iq_dump_decimator #(
  parameter int DW         = 12,
  parameter int LOG2_DECIM = 4,
  parameter int OW         = DW + LOG2_DECIM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] data_i,
  input  logic                 valid_i,
  output logic signed [OW-1:0] data_o,
  output logic                 valid_o,
  output logic                 err_o
);

  // Handshake: valid_i has no back-pressure; each pair is two consecutive valid
  // cycles (re, im). valid_o frames each output pair the same way, one cycle per word.
  localparam int DECIM = 1 << LOG2_DECIM;

  typedef enum logic {WAIT_RE = 1'b0, WAIT_IM = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic signed [DW-1:0]   re_hold_q, re_hold_d;
  logic signed [OW-1:0]   acc_re_q, acc_im_q;
  logic [LOG2_DECIM-1:0]  cnt_q;
  logic signed [OW-1:0]   data_q, im_pend_q;
  logic                   valid_q, err_q, seq_q;

  logic                   accept, frame_err, dump;
  logic signed [OW-1:0]   sum_re, sum_im, out_re, out_im;

  always_comb begin
    state_d   = state_q;
    re_hold_d = re_hold_q;
    accept    = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      WAIT_RE: begin
        if (valid_i) begin
          re_hold_d = data_i;
          state_d   = WAIT_IM;
        end
      end
      WAIT_IM: begin
        state_d = WAIT_RE;
        if (valid_i) begin
          accept = 1'b1;
        end else begin
          frame_err = 1'b1;
          re_hold_d = '0;
        end
      end
      default: state_d = WAIT_RE;
    endcase
  end

  // Sign-extended running sums including the pair being accepted this cycle.
  assign sum_re = acc_re_q + OW'(re_hold_q);
  assign sum_im = acc_im_q + OW'(data_i);
  assign dump   = accept && (cnt_q == LOG2_DECIM'(DECIM - 1));

`ifdef IQ_DECIM_AVG_EN
  assign out_re = sum_re >>> LOG2_DECIM;
  assign out_im = sum_im >>> LOG2_DECIM;
`else
  assign out_re = sum_re;
  assign out_im = sum_im;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= WAIT_RE;
      re_hold_q <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      im_pend_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      re_hold_q <= re_hold_d;
      err_q     <= frame_err;
      if (accept) begin
        if (dump) begin
          acc_re_q <= '0;
          acc_im_q <= '0;
          cnt_q    <= '0;
        end else begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
          cnt_q    <= cnt_q + 1'b1;
        end
      end
      // Output sequencer: re on the cycle after the dump, im on the next one.
      if (dump) begin
        valid_q   <= 1'b1;
        data_q    <= out_re;
        im_pend_q <= out_im;
        seq_q     <= 1'b1;
      end else if (seq_q) begin
        data_q <= im_pend_q;
        seq_q  <= 1'b0;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_iq_dump_decimator.sv
// Self-checking bench for iq_dump_decimator: directed plan steps plus random pairs,
// compared against a pair-level sum/average model (honours IQ_DECIM_AVG_EN).
module tb_iq_dump_decimator;
  localparam int DW = 12;
  localparam int L2 = 4;
  localparam int OW = DW + L2;
  localparam int D  = 1 << L2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] data_i = '0;
  logic                 valid_i = 1'b0;
  logic signed [OW-1:0] data_o;
  logic                 valid_o;
  logic                 err_o;

  iq_dump_decimator #(.DW(DW), .LOG2_DECIM(L2), .OW(OW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected output words and the edge on which each pair is due.
  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_pairs = 0;
  int            sum_re = 0;
  int            sum_im = 0;
  int            exp_err = 0;
  int            seen_err = 0;

  function automatic int model_out(input int s);
`ifdef IQ_DECIM_AVG_EN
    if (s >= 0) return s / D;
    return -(((-s) + D - 1) / D);
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Caller is always positioned #1 after a rising edge.
  task automatic send_pair(input int re, input int im, input int gap);
    logic [OW-1:0] t;
    valid_i = 1'b1;
    data_i  = DW'(re);
    @(posedge clk); #1;
    data_i  = DW'(im);
    @(posedge clk); #1;
    sum_re += re;
    sum_im += im;
    n_pairs++;
    if (n_pairs == D) begin
      t = OW'(model_out(sum_re)); exp_q.push_back(t);
      t = OW'(model_out(sum_im)); exp_q.push_back(t);
      exp_cyc_q.push_back(cyc);
      n_pairs = 0; sum_re = 0; sum_im = 0;
    end
    if (gap > 0) begin
      valid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Lone valid cycle: a re that never gets its im.
  task automatic send_single(input int re);
    valid_i = 1'b1;
    data_i  = DW'(re);
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = '0;
    @(posedge clk); #1;
    exp_err++;
    check("err_pulse", OW'(err_o), OW'(1));
    @(posedge clk); #1;
    check("err_clear", OW'(err_o), OW'(0));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    valid_i = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      check("rst_valid_o", OW'(valid_o), OW'(0));
    end
    check("rst_data_o", data_o, OW'(0));
    check("rst_err_o", OW'(err_o), OW'(0));
    rst = 1'b1;
    n_pairs = 0; sum_re = 0; sum_im = 0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Output monitor, sampled on the falling edge.
  bit prev_v = 1'b0;
  int run_len = 0;
  always @(negedge clk) begin
    if (rst && err_o) seen_err++;
    if (rst && valid_o) begin
      if (!prev_v) begin
        if (exp_cyc_q.size() == 0) begin
          check("unexpected_pair", OW'(1), OW'(0));
        end else begin
          check("latency", OW'(cyc), OW'(exp_cyc_q.pop_front()));
        end
      end
      if (exp_q.size() == 0) check("unexpected_word", data_o, OW'(0) ^ data_o ^ OW'(1));
      else check(prev_v ? "data_im" : "data_re", data_o, exp_q.pop_front());
      run_len++;
    end else if (prev_v) begin
      check("valid_len", OW'(run_len), OW'(2));
      run_len = 0;
    end
    prev_v = rst && valid_o;
  end

  initial begin
    int re, im;
    do_reset(3);
    idle(2);

    // Constant input.
    for (int i = 0; i < D; i++) send_pair(100, -50, 8);
    idle(6);

    // Extremes, then ones to show the accumulators were cleared.
    for (int i = 0; i < D; i++) send_pair(-2048, 2047, 1);
    for (int i = 0; i < D; i++) send_pair(1, 1, 1);
    idle(6);

    // Framing error in the middle of an accumulation.
    for (int i = 0; i < 5; i++) send_pair(10, 10, 2);
    send_single(999);
    for (int i = 0; i < 11; i++) send_pair(10, 10, 2);
    idle(6);

    // Reset mid-accumulation.
    for (int i = 0; i < 8; i++) send_pair(7, 7, 1);
    do_reset(1);
    for (int i = 0; i < D; i++) send_pair(3, -3, 1);
    idle(6);

    // Back-to-back pairs, then an odd trailing cycle on the same burst.
    for (int i = 0; i < 2 * D; i++) send_pair(1, 2, 0);
    send_pair(5, 6, 0);
    send_single(77);
    for (int i = 1; i < D; i++) send_pair(5, 6, 1);
    idle(6);

    // Floor behaviour of the averaging build (sums 15/-15 otherwise).
    for (int i = 0; i < D - 1; i++) send_pair(1, -1, 1);
    send_pair(0, 0, 1);
    idle(6);

    // Random pairs, gaps and occasional framing errors.
    for (int i = 0; i < 120; i++) begin
      re = int'($urandom_range(0, 4095)) - 2048;
      im = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 15) == 0) send_single(re);
      send_pair(re, im, int'($urandom_range(0, 3)));
    end
    idle(10);

    check("exp_q_drained", OW'(exp_q.size()), OW'(0));
    check("err_count", OW'(seen_err), OW'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
